syn_core_run_ctl: RTL and testbench

//  Parametrised run controller for the single-cycle core. Drives the core's en, replacing the bare en pin with

---
 rtl/syn_core_run_ctl.sv | 135 +++++++++++++
 tb/tb_syn_core_run_ctl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/syn_core_run_ctl.sv
// Run controller for the single-cycle core: gates core_en for free-run, single-step,
// N-step and PC-breakpoint operation, and keeps saturating retirement statistics.
module syn_core_run_ctl #(
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16,
    parameter int N_BP   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             run_mode,
    input  logic                   go,
    input  logic [STEP_W-1:0]      step_cnt,
    input  logic [N_BP-1:0]        bp_en,
    input  logic [N_BP*PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]        pc,
    input  logic                   halt,
    input  logic                   is_jump,
    input  logic                   is_branch,
    input  logic                   branched,
    input  logic                   clr_stats,
    output logic                   core_en,
    output logic [1:0]             state,
    output logic [N_BP-1:0]        bp_hit,
    output logic [STEP_W-1:0]      steps_left,
    output logic [CNT_W-1:0]       cyc_cnt,
    output logic [CNT_W-1:0]       jump_cnt,
    output logic [CNT_W-1:0]       branch_cnt,
    output logic [CNT_W-1:0]       taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10,
        S_BREAK  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_NSTEP = 2'b11;

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            cur_state;
    logic              skip_bp;
    logic [N_BP-1:0]   match_vec;
    logic              bp_match;
    logic              go_ok;

    assign state = cur_state;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < N_BP; i++) begin
            match_vec[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
        end
    end

    assign bp_match = (|match_vec) & ~skip_bp;
    assign core_en  = (cur_state == S_RUN) & ~halt & ~bp_match & (run_mode != MODE_STOP);

    // An N-step request for zero instructions is treated as no request at all.
    assign go_ok = go && (run_mode != MODE_STOP) &&
                   !((run_mode == MODE_NSTEP) && (step_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_IDLE;
            steps_left <= '0;
            bp_hit     <= '0;
            skip_bp    <= 1'b0;
        end else begin
            case (cur_state)
                S_IDLE, S_BREAK: begin
                    if (go_ok) begin
                        cur_state <= S_RUN;
                        skip_bp   <= 1'b1;
                        bp_hit    <= '0;
                        case (run_mode)
                            MODE_FREE: steps_left <= '0;
                            MODE_STEP: steps_left <= STEP_ONE;
                            default:   steps_left <= step_cnt;
                        endcase
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        cur_state <= S_HALTED;
                    end else if (run_mode == MODE_STOP) begin
                        cur_state <= S_IDLE;
                    end else if (bp_match) begin
                        cur_state <= S_BREAK;
                        bp_hit    <= match_vec;
                    end else begin
                        skip_bp <= 1'b0;
                        if (steps_left == STEP_ONE) begin
                            cur_state  <= S_IDLE;
                            steps_left <= '0;
                        end else if (steps_left != '0) begin
                            steps_left <= steps_left - STEP_ONE;
                        end
                    end
                end
                default: cur_state <= S_HALTED;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && !(&v)) ? v + CNT_ONE : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt    <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (clr_stats) begin
            cyc_cnt    <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (core_en) begin
            cyc_cnt    <= sat_inc(cyc_cnt, 1'b1);
            jump_cnt   <= sat_inc(jump_cnt, is_jump);
            branch_cnt <= sat_inc(branch_cnt, is_branch);
            taken_cnt  <= sat_inc(taken_cnt, is_branch & branched);
        end
    end

endmodule

// File: tb/tb_syn_core_run_ctl.sv
// Bench for syn_core_run_ctl: a behavioural model checked every cycle, plus directed
// scenarios with hand-computed expectations (4-bit counters to reach saturation).
module tb_syn_core_run_ctl;

    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam int STEP_W = 16;
    localparam int N_BP   = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           run_mode;
    logic                 go;
    logic [STEP_W-1:0]    step_cnt;
    logic [N_BP-1:0]      bp_en;
    logic [N_BP*PC_W-1:0] bp_addr;
    logic [PC_W-1:0]      pc;
    logic                 halt, is_jump, is_branch, branched, clr_stats;
    logic                 core_en;
    logic [1:0]           state;
    logic [N_BP-1:0]      bp_hit;
    logic [STEP_W-1:0]    steps_left;
    logic [CNT_W-1:0]     cyc_cnt, jump_cnt, branch_cnt, taken_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int en_count = 0;

    syn_core_run_ctl #(.PC_W(PC_W), .CNT_W(CNT_W), .STEP_W(STEP_W), .N_BP(N_BP)) dut (
        .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .go(go), .step_cnt(step_cnt),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .halt(halt), .is_jump(is_jump),
        .is_branch(is_branch), .branched(branched), .clr_stats(clr_stats),
        .core_en(core_en), .state(state), .bp_hit(bp_hit), .steps_left(steps_left),
        .cyc_cnt(cyc_cnt), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: 0 idle, 1 run, 2 halted, 3 break
    int        m_state, m_steps, m_cyc, m_jump, m_br, m_taken;
    bit        m_skip;
    logic [1:0] m_hit;

    function automatic logic [1:0] m_matches();
        logic [1:0] r = '0;
        for (int i = 0; i < N_BP; i++)
            if (bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit m_en();
        return m_state == 1 && !halt && run_mode != 2'b00 && !(m_matches() != 0 && !m_skip);
    endfunction

    function automatic int sat(input int v, input bit inc);
        return (inc && v < CMAX) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_steps = 0; m_skip = 0; m_hit = '0;
            m_cyc = 0; m_jump = 0; m_br = 0; m_taken = 0;
        end else begin
            automatic bit        en  = m_en();
            automatic logic [1:0] mt = m_matches();
            if (clr_stats) begin
                m_cyc = 0; m_jump = 0; m_br = 0; m_taken = 0;
            end else if (en) begin
                m_cyc = sat(m_cyc, 1); m_jump = sat(m_jump, is_jump);
                m_br = sat(m_br, is_branch); m_taken = sat(m_taken, is_branch && branched);
            end
            if (m_state == 0 || m_state == 3) begin
                if (go && run_mode != 0 && !(run_mode == 3 && step_cnt == 0)) begin
                    m_state = 1; m_skip = 1; m_hit = '0;
                    m_steps = (run_mode == 1) ? 0 : (run_mode == 2) ? 1 : int'(step_cnt);
                end
            end else if (m_state == 1) begin
                if (halt) m_state = 2;
                else if (run_mode == 0) m_state = 0;
                else if (mt != 0 && !m_skip) begin m_state = 3; m_hit = mt; end
                else begin
                    m_skip = 0;
                    if (m_steps == 1) begin m_state = 0; m_steps = 0; end
                    else if (m_steps > 0) m_steps--;
                end
            end
        end
    end

    // compare process, mid-cycle
    always @(negedge clk) begin
        if (core_en) en_count++;
        check("core_en", core_en, m_en());
        check("state", state, m_state);
        check("steps_left", steps_left, m_steps);
        check("bp_hit", bp_hit, m_hit);
        check("cyc_cnt", cyc_cnt, m_cyc);
        check("jump_cnt", jump_cnt, m_jump);
        check("branch_cnt", branch_cnt, m_br);
        check("taken_cnt", taken_cnt, m_taken);
    end

    // driver tasks; pc advances like the core would after each enabled cycle
    task automatic tick(input int n);
        bit en_s;
        repeat (n) begin
            @(negedge clk); en_s = core_en;
            @(posedge clk); #1;
            if (en_s) pc = pc + 32'd4;
        end
    endtask

    task automatic pulse_go(input logic [1:0] mode, input logic [STEP_W-1:0] cnt);
        run_mode = mode; step_cnt = cnt; go = 1'b1;
        tick(1);
        go = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pc = '0;
        tick(2);
        rst_n = 1'b1; en_count = 0;
    endtask

    initial begin
        rst_n = 1'b0; run_mode = 2'b00; go = 1'b0; step_cnt = '0; bp_en = '0;
        bp_addr = {32'h0000_0100, 32'h0000_0010}; pc = '0; halt = 1'b0; is_jump = 1'b0;
        is_branch = 1'b0; branched = 1'b0; clr_stats = 1'b0;
        do_reset();
        check("reset_state", state, 2'b00);
        check("reset_cyc", cyc_cnt, 0);

        // 1: free run, halt on the 6th run cycle
        pulse_go(2'b01, '0);
        tick(5);
        halt = 1'b1; tick(1); halt = 1'b0;
        check("t1_en_cycles", en_count, 5);
        check("t1_cyc", cyc_cnt, 5);
        check("t1_halted", state, 2'b10);
        pulse_go(2'b01, '0); tick(2);
        check("t1_go_ignored", state, 2'b10);

        // 2: N-step 3, then N-step 0
        do_reset();
        pulse_go(2'b11, 16'd3);
        check("t2_steps3", steps_left, 3); tick(1);
        check("t2_steps2", steps_left, 2); tick(1);
        check("t2_steps1", steps_left, 1); tick(1);
        check("t2_steps0", steps_left, 0);
        check("t2_idle", state, 2'b00);
        check("t2_en_cycles", en_count, 3);
        pulse_go(2'b11, 16'd0); tick(3);
        check("t2_zero_idle", state, 2'b00);
        check("t2_zero_no_en", en_count, 3);

        // 3: breakpoint at 0x10 on channel 0, then single step past it
        do_reset();
        bp_en = 2'b01;
        pulse_go(2'b01, '0);
        for (int i = 0; i < 30 && state != 2'b11; i++) tick(1);
        check("t3_break", state, 2'b11);
        check("t3_pc", pc, 32'h10);
        check("t3_bp_hit", bp_hit, 2'b01);
        check("t3_en_cycles", en_count, 4);
        pulse_go(2'b10, '0); tick(1);
        check("t3_idle", state, 2'b00);
        check("t3_pc_after", pc, 32'h14);
        check("t3_hit_clr", bp_hit, 2'b00);
        bp_en = 2'b00;

        // 4: saturation with 4-bit counters over 20 branch cycles
        do_reset();
        is_branch = 1'b1;
        pulse_go(2'b01, '0);
        for (int i = 0; i < 20; i++) begin
            branched = (i % 2 == 0);
            tick(1);
        end
        run_mode = 2'b00; is_branch = 1'b0; branched = 1'b0;
        tick(1);
        check("t4_en_cycles", en_count, 20);
        check("t4_cyc", cyc_cnt, 15);
        check("t4_branch", branch_cnt, 15);
        check("t4_taken", taken_cnt, 10);
        check("t4_idle", state, 2'b00);

        // 5: clear beats a same-cycle increment, FSM keeps running
        pulse_go(2'b01, '0);
        is_jump = 1'b1; clr_stats = 1'b1; tick(1);
        is_jump = 1'b0; clr_stats = 1'b0;
        check("t5_cyc", cyc_cnt, 0);
        check("t5_jump", jump_cnt, 0);
        check("t5_taken", taken_cnt, 0);
        check("t5_run", state, 2'b01);
        run_mode = 2'b00; tick(1);

        // 6: asynchronous reset in the middle of an N-step run
        do_reset();
        pulse_go(2'b11, 16'd100);
        tick(40);
        check("t6_steps60", steps_left, 60);
        check("t6_en40", en_count, 40);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_en", core_en, 1'b0);
        check("t6_async_state", state, 2'b00);
        check("t6_async_steps", steps_left, 0);
        check("t6_async_cyc", cyc_cnt, 0);
        tick(2);
        rst_n = 1'b1; pc = '0;
        pulse_go(2'b10, '0); tick(2);
        check("t6_restart_cyc", cyc_cnt, 1);
        check("t6_restart_idle", state, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
